// File: rtl/hazard_lights_sched_if.sv
// Lamp bus between the hazard-light scheduler and the rest of the system:
// enable and requests go in, the lamp pattern, the active mode and the frame strobe come out.
interface hazard_lights_sched_if;
  logic       en;
  logic       req_calm;
  logic       req_left;
  logic       req_right;
  logic [2:0] out;
  logic [1:0] mode;
  logic       step_tick;

  modport master (
    output en, req_calm, req_left, req_right,
    input  out, mode, step_tick
  );

  modport slave (
    input  en, req_calm, req_left, req_right,
    output out, mode, step_tick
  );
endinterface

// File: rtl/hazard_lights_sched.sv
// Hazard-light scheduler: arbitrates the requests, paces frames with a prescaler and switches
// mode only at pattern boundaries. Optional LIGHTS_BLANK_EN inserts one blank GAP frame between different modes.
module hazard_lights_sched #(
  parameter int unsigned TICK_DIV = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  hazard_lights_sched_if.slave bus
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef LIGHTS_BLANK_EN
  localparam int unsigned SW = 3;
`else
  localparam int unsigned SW = 2;
`endif

  // The low two bits of the state encoding are the mode value; GAP reads back as 00.
  typedef enum logic [SW-1:0] {
    S_OFF,
    S_CALM,
    S_WL,
    S_WR
`ifdef LIGHTS_BLANK_EN
    , S_GAP
`endif
  } state_t;

  state_t        state, state_nxt, req_mode;
  logic [1:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    out_nxt;
  logic          tick;

  function automatic logic [2:0] frame_of(input state_t s, input logic [1:0] i);
    logic [2:0] f;
    f = 3'b000;
    case (s)
      S_CALM:  f = (i == 2'd0) ? 3'b101 : 3'b010;
      S_WL:    case (i) 2'd0: f = 3'b001; 2'd1: f = 3'b010; default: f = 3'b100; endcase
      S_WR:    case (i) 2'd0: f = 3'b100; 2'd1: f = 3'b010; default: f = 3'b001; endcase
      default: f = 3'b000;
    endcase
    return f;
  endfunction

  function automatic logic [1:0] last_of(input state_t s);
    logic [1:0] l;
    case (s)
      S_CALM:     l = 2'd1;
      S_WL, S_WR: l = 2'd2;
      default:    l = 2'd0;
    endcase
    return l;
  endfunction

  always_comb begin
    if (bus.req_calm || (bus.req_left && bus.req_right)) req_mode = S_CALM;
    else if (bus.req_left)                               req_mode = S_WL;
    else if (bus.req_right)                              req_mode = S_WR;
    else                                                 req_mode = S_OFF;
  end

  always_comb begin
    tick      = bus.en && (cnt == CW'(TICK_DIV - 1));
    state_nxt = state;
    idx_nxt   = idx;
    out_nxt   = bus.out;
    cnt_nxt   = cnt;
    if (bus.en) cnt_nxt = tick ? '0 : cnt + CW'(1);
    if (tick) begin
      // ">=" makes any out-of-range idx count as a boundary, so it recovers to frame 0.
      if (idx >= last_of(state)) begin
        state_nxt = req_mode;
        idx_nxt   = '0;
        out_nxt   = frame_of(req_mode, 2'd0);
`ifdef LIGHTS_BLANK_EN
        if (state != S_OFF && state != S_GAP && req_mode != S_OFF && req_mode != state) begin
          state_nxt = S_GAP;
          out_nxt   = '0;
        end
`endif
      end else begin
        idx_nxt = idx + 2'd1;
        out_nxt = frame_of(state, idx + 2'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_OFF;
      idx           <= '0;
      cnt           <= '0;
      bus.out       <= '0;
      bus.step_tick <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      cnt           <= cnt_nxt;
      bus.out       <= out_nxt;
      bus.step_tick <= tick;
    end
  end

  assign bus.mode = state[1:0];

endmodule

// File: tb/tb_hazard_lights_sched.sv
// Directed bench for hazard_lights_sched: a TICK_DIV=4 instance covers the main scenarios,
// and a TICK_DIV=1 instance covers one-frame-per-cycle pacing.
module tb_hazard_lights_sched;
  logic clk;
  logic rst_a, rst_b;
  int   checks;
  int   errors;
  string phase;

  hazard_lights_sched_if a ();
  hazard_lights_sched_if b ();

  hazard_lights_sched #(.TICK_DIV(4)) dut_a (.clk(clk), .reset_n(rst_a), .bus(a.slave));
  hazard_lights_sched #(.TICK_DIV(1)) dut_b (.clk(clk), .reset_n(rst_b), .bus(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  task automatic cyc_a(input logic [2:0] o, input logic [1:0] m, input logic s);
    @(posedge clk); #1;
    chk("a.out",  {5'd0, a.out},       {5'd0, o});
    chk("a.mode", {6'd0, a.mode},      {6'd0, m});
    chk("a.step", {7'd0, a.step_tick}, {7'd0, s});
  endtask

  task automatic frame_a(input logic [2:0] o, input logic [1:0] m);
    cyc_a(o, m, 1'b1);
    repeat (3) cyc_a(o, m, 1'b0);
  endtask

  task automatic cyc_b(input logic [2:0] o, input logic [1:0] m, input logic s);
    @(posedge clk); #1;
    chk("b.out",  {5'd0, b.out},       {5'd0, o});
    chk("b.mode", {6'd0, b.mode},      {6'd0, m});
    chk("b.step", {7'd0, b.step_tick}, {7'd0, s});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    phase  = "reset";
    rst_a = 1'b0; rst_b = 1'b0;
    a.en = 1'b1; a.req_calm = 1'b0; a.req_left = 1'b0; a.req_right = 1'b0;
    b.en = 1'b1; b.req_calm = 1'b0; b.req_left = 1'b0; b.req_right = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc_a(3'b000, 2'b00, 1'b0);
    cyc_b(3'b000, 2'b00, 1'b0);

    // CALM from reset release: blank for three edges, first frame on the fourth
    phase = "calm";
    a.req_calm = 1'b1;
    rst_a = 1'b1;
    repeat (3) cyc_a(3'b000, 2'b00, 1'b0);
    frame_a(3'b101, 2'b01);
    frame_a(3'b010, 2'b01);
    frame_a(3'b101, 2'b01);

    phase = "both_wind";
    a.req_calm = 1'b0; a.req_left = 1'b1; a.req_right = 1'b1;
    frame_a(3'b010, 2'b01);
    frame_a(3'b101, 2'b01);
    frame_a(3'b010, 2'b01);

    phase = "calm_to_wl";
    a.req_right = 1'b0;
`ifdef LIGHTS_BLANK_EN
    frame_a(3'b000, 2'b00);
`endif
    frame_a(3'b001, 2'b10);
    frame_a(3'b010, 2'b10);

    phase = "wl_to_wr";
    a.req_left = 1'b0; a.req_right = 1'b1;
    frame_a(3'b100, 2'b10);
`ifdef LIGHTS_BLANK_EN
    frame_a(3'b000, 2'b00);
`endif
    frame_a(3'b100, 2'b11);
    frame_a(3'b010, 2'b11);
    frame_a(3'b001, 2'b11);

    phase = "freeze";
    cyc_a(3'b100, 2'b11, 1'b1);
    cyc_a(3'b100, 2'b11, 1'b0);
    cyc_a(3'b100, 2'b11, 1'b0);
    a.en = 1'b0;
    repeat (10) cyc_a(3'b100, 2'b11, 1'b0);
    a.en = 1'b1;
    cyc_a(3'b100, 2'b11, 1'b0);
    cyc_a(3'b010, 2'b11, 1'b1);

    phase = "mid_reset";
    a.req_left = 1'b1; a.req_right = 1'b0;
    repeat (3) cyc_a(3'b010, 2'b11, 1'b0);
    frame_a(3'b001, 2'b11);
`ifdef LIGHTS_BLANK_EN
    frame_a(3'b000, 2'b00);
`endif
    frame_a(3'b001, 2'b10);
    cyc_a(3'b010, 2'b10, 1'b1);
    rst_a = 1'b0;
    cyc_a(3'b000, 2'b00, 1'b0);
    cyc_a(3'b000, 2'b00, 1'b0);
    rst_a = 1'b1;
    repeat (3) cyc_a(3'b000, 2'b00, 1'b0);
    frame_a(3'b001, 2'b10);
    frame_a(3'b010, 2'b10);
    frame_a(3'b100, 2'b10);

    phase = "off_pulse";
    a.req_left = 1'b0;
    frame_a(3'b000, 2'b00);
    frame_a(3'b000, 2'b00);

    // one frame per enabled cycle
    phase = "div1";
    b.req_left = 1'b1;
    rst_b = 1'b1;
    cyc_b(3'b001, 2'b10, 1'b1);
    cyc_b(3'b010, 2'b10, 1'b1);
    cyc_b(3'b100, 2'b10, 1'b1);
    b.req_calm = 1'b1;
`ifdef LIGHTS_BLANK_EN
    cyc_b(3'b000, 2'b00, 1'b1);
`endif
    cyc_b(3'b101, 2'b01, 1'b1);
    cyc_b(3'b010, 2'b01, 1'b1);
    b.en = 1'b0;
    repeat (3) cyc_b(3'b010, 2'b01, 1'b0);
    b.en = 1'b1;
    cyc_b(3'b101, 2'b01, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
